axis_arb_mux_stage: RTL and testbench

// - AXI-stream N:1 frame mux that sits directly downstream of the arbiter. It consumes

---
 rtl/axis_arb_mux_stage.sv | 131 +++++++++++++
 tb/tb_axis_arb_mux_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_arb_mux_stage.sv
// AXI-stream N:1 frame mux driven by a blocking arbiter; one registered output stage.
// Define AXIS_ARB_MUX_SKID_EN to add a 1-entry skid register that breaks the ready path.
module axis_arb_mux_stage #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [PORTS-1:0]              arb_request,
  output logic [PORTS-1:0]              arb_acknowledge,
  input  logic [PORTS-1:0]              arb_grant,
  input  logic                          arb_grant_valid,
  input  logic [$clog2(PORTS)-1:0]      arb_grant_encoded
);

  localparam int ENC_W = $clog2(PORTS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  beat_t sel_beat;
  logic  sel_valid;
  logic  sel_grant;
  logic  sel_ok;
  logic  int_ready;
  logic  xfer;
  beat_t out_q;
  logic  out_valid;

  // An encoded index outside 0..PORTS-1 matches no port, so sel_ok stays low.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    sel_grant = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (arb_grant_encoded == ENC_W'(i)) begin
        sel_beat.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_beat.keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_beat.last = s_axis_tlast[i];
        sel_beat.user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid     = s_axis_tvalid[i];
        sel_grant     = arb_grant[i];
      end
    end
  end

  assign sel_ok          = arb_grant_valid & sel_grant;
  assign s_axis_tready   = (rst_n && sel_ok && int_ready) ? arb_grant : '0;
  assign xfer            = rst_n & sel_ok & int_ready & sel_valid;
  assign arb_request     = s_axis_tvalid;
  // Ack fires on the accepting cycle of the last beat so the arbiter re-grants at that edge.
  assign arb_acknowledge = s_axis_tvalid & s_axis_tready & s_axis_tlast;

`ifdef AXIS_ARB_MUX_SKID_EN
  beat_t skid_q;
  logic  skid_valid;

  // Ready depends only on the skid flag, so m_axis_tready never reaches s_axis_tready.
  assign int_ready = !skid_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: data registers are reset too; it is cheap here and keeps m_axis_tdata defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_valid  <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || m_axis_tready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (xfer) begin
        out_q     <= sel_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (xfer) begin
      skid_q     <= sel_beat;
      skid_valid <= 1'b1;
    end
  end

  skid_implies_out_valid: assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid |-> out_valid);
`else
  assign int_ready = !out_valid || m_axis_tready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: data registers are reset too; it is cheap here and keeps m_axis_tdata defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_q     <= sel_beat;
      out_valid <= 1'b1;
    end else if (m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tvalid = out_valid;

endmodule

// File: tb/tb_axis_arb_mux_stage.sv
// Directed bench for axis_arb_mux_stage: combinational vector table plus frame sequences.
module tb_axis_arb_mux_stage;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int KW    = 1;
  localparam int UW    = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     d [PORTS];
  logic [PORTS-1:0]  tvalid, tlast, tuser;
  logic [PORTS*DW-1:0] s_axis_tdata;
  logic [PORTS*KW-1:0] s_axis_tkeep;
  logic [PORTS-1:0]  s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [UW-1:0]     m_axis_tuser;
  logic [PORTS-1:0]  arb_request, arb_acknowledge, arb_grant;
  logic              arb_grant_valid;
  logic [1:0]        arb_grant_encoded;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign s_axis_tdata = {d[3], d[2], d[1], d[0]};
  assign s_axis_tkeep = '1;

  axis_arb_mux_stage #(.PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .arb_request(arb_request), .arb_acknowledge(arb_acknowledge), .arb_grant(arb_grant),
    .arb_grant_valid(arb_grant_valid), .arb_grant_encoded(arb_grant_encoded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       gv;
    logic [3:0] grant;
    logic [1:0] enc;
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] exp_tready;
    logic [3:0] exp_ack;
    logic       exp_xfer;
  } vec_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
  } sbeat_t;

  sbeat_t beats[$];
  bit     rdy_pat[$];
  int     gap_start = -1;
  int     gap_len   = 0;

  // Bench acts as the arbiter: grant follows the frame of the next unsent beat,
  // so it moves to the next frame on the edge after the last-beat ack.
  task automatic run_seq(input string tag, input bit chk_lat, input bit chk_nobubble);
    int n = beats.size();
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int first_out = -1;
    int last_out = -1;
    int acc_cyc[$];
    int p = 0;
    bit mr, gv, acc;
    logic [3:0] tr_save;
    while ((in_idx < n || out_idx < n) && cyc < 100) begin
      @(negedge clk);
      mr = rdy_pat[cyc % rdy_pat.size()];
      m_axis_tready = mr;
      if (m_axis_tvalid && mr) begin
        if (out_idx < n) begin
          check({tag, " data"}, 32'(m_axis_tdata), 32'(beats[out_idx].data));
          check({tag, " last"}, 32'(m_axis_tlast), 32'(beats[out_idx].last));
          check({tag, " user"}, 32'(m_axis_tuser), 32'(beats[out_idx].port % 2));
          if (chk_lat) check({tag, " latency"}, 32'(cyc), 32'(acc_cyc[out_idx] + 1));
        end else begin
          check({tag, " extra beat"}, 32'(m_axis_tdata), 32'hFFFF_FFFF);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_idx++;
      end
      gv = !(cyc >= gap_start && cyc < gap_start + gap_len);
      arb_grant_valid = gv;
      if (in_idx < n) begin
        p = beats[in_idx].port;
        arb_grant         = 4'(1 << p);
        arb_grant_encoded = 2'(p);
        tvalid            = 4'(1 << p);
        tlast             = beats[in_idx].last ? 4'(1 << p) : 4'b0000;
        d[p]              = beats[in_idx].data;
      end else begin
        tvalid = '0;
        tlast  = '0;
      end
      #1;
`ifdef AXIS_ARB_MUX_SKID_EN
      tr_save = s_axis_tready;
      m_axis_tready = !mr;
      #1;
      check({tag, " ready independent of m_tready"}, 32'(s_axis_tready), 32'(tr_save));
      m_axis_tready = mr;
      #1;
`else
      tr_save = '0;
`endif
      acc = (in_idx < n) && s_axis_tready[p];
      check({tag, " ack"}, 32'(arb_acknowledge),
            (acc && beats[in_idx].last) ? 32'(1 << p) : 32'h0);
      if (!gv) check({tag, " tready in grant gap"}, 32'(s_axis_tready), 32'h0);
      if (acc) begin
        acc_cyc.push_back(cyc);
        in_idx++;
      end
      cyc++;
    end
    check({tag, " beats accepted"}, 32'(in_idx), 32'(n));
    check({tag, " beats delivered"}, 32'(out_idx), 32'(n));
    if (chk_nobubble) check({tag, " no bubble"}, 32'(last_out - first_out), 32'(n - 1));
    tvalid = '0;
    tlast  = '0;
    m_axis_tready = 1'b1;
    gap_start = -1;
    gap_len   = 0;
    @(negedge clk);
    check({tag, " idle after frame"}, 32'(m_axis_tvalid), 32'h0);
    beats.delete();
    rdy_pat.delete();
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{gv:1'b0, grant:4'b0001, enc:2'd0, valid:4'b1111, last:4'b0000, exp_tready:4'b0000, exp_ack:4'b0000, exp_xfer:1'b0};
    vecs[1] = '{gv:1'b1, grant:4'b0001, enc:2'd0, valid:4'b0001, last:4'b0000, exp_tready:4'b0001, exp_ack:4'b0000, exp_xfer:1'b1};
    vecs[2] = '{gv:1'b1, grant:4'b0100, enc:2'd2, valid:4'b0100, last:4'b0100, exp_tready:4'b0100, exp_ack:4'b0100, exp_xfer:1'b1};
    vecs[3] = '{gv:1'b1, grant:4'b0100, enc:2'd1, valid:4'b1111, last:4'b1111, exp_tready:4'b0000, exp_ack:4'b0000, exp_xfer:1'b0};
    vecs[4] = '{gv:1'b1, grant:4'b1000, enc:2'd3, valid:4'b0000, last:4'b1000, exp_tready:4'b1000, exp_ack:4'b0000, exp_xfer:1'b0};
    vecs[5] = '{gv:1'b1, grant:4'b0010, enc:2'd1, valid:4'b1101, last:4'b1111, exp_tready:4'b0010, exp_ack:4'b0000, exp_xfer:1'b0};
    vecs[6] = '{gv:1'b1, grant:4'b0000, enc:2'd0, valid:4'b1111, last:4'b1111, exp_tready:4'b0000, exp_ack:4'b0000, exp_xfer:1'b0};
    vecs[7] = '{gv:1'b1, grant:4'b1000, enc:2'd3, valid:4'b1000, last:4'b1000, exp_tready:4'b1000, exp_ack:4'b1000, exp_xfer:1'b1};

    for (int i = 0; i < PORTS; i++) d[i] = '0;
    tuser             = 4'b1010;
    tvalid            = 4'b1111;
    tlast             = 4'b1111;
    arb_grant         = 4'b0001;
    arb_grant_valid   = 1'b1;
    arb_grant_encoded = 2'd0;
    m_axis_tready     = 1'b1;

    // Reset held with everything requesting: nothing may leak through.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset m_tvalid", 32'(m_axis_tvalid), 32'h0);
      check("reset s_tready", 32'(s_axis_tready), 32'h0);
      check("reset ack", 32'(arb_acknowledge), 32'h0);
    end
    check("reset m_tdata", 32'(m_axis_tdata), 32'h0);
    rst_n  = 1'b1;
    tvalid = '0;
    tlast  = '0;

    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      for (int i = 0; i < PORTS; i++) d[i] = 8'(16 * r + i);
      arb_grant_valid   = vecs[r].gv;
      arb_grant         = vecs[r].grant;
      arb_grant_encoded = vecs[r].enc;
      tvalid            = vecs[r].valid;
      tlast             = vecs[r].last;
      #1;
      check($sformatf("vec%0d tready", r), 32'(s_axis_tready), 32'(vecs[r].exp_tready));
      check($sformatf("vec%0d ack", r), 32'(arb_acknowledge), 32'(vecs[r].exp_ack));
      check($sformatf("vec%0d request", r), 32'(arb_request), 32'(vecs[r].valid));
      @(negedge clk);
      check($sformatf("vec%0d m_tvalid", r), 32'(m_axis_tvalid), 32'(vecs[r].exp_xfer));
      if (vecs[r].exp_xfer) begin
        check($sformatf("vec%0d m_tdata", r), 32'(m_axis_tdata), 32'(16 * r + vecs[r].enc));
        check($sformatf("vec%0d m_tlast", r), 32'(m_axis_tlast), 32'(vecs[r].last[vecs[r].enc]));
        check($sformatf("vec%0d m_tuser", r), 32'(m_axis_tuser), 32'(vecs[r].enc[0]));
      end
      tvalid = '0;
      tlast  = '0;
    end

    // Single 3-beat frame on port 1.
    beats.push_back('{port:1, data:8'hA1, last:1'b0});
    beats.push_back('{port:1, data:8'hA2, last:1'b0});
    beats.push_back('{port:1, data:8'hA3, last:1'b1});
    rdy_pat.push_back(1'b1);
    run_seq("single", 1'b1, 1'b1);

    // Back-to-back frames, port 0 then port 2.
    beats.push_back('{port:0, data:8'h01, last:1'b0});
    beats.push_back('{port:0, data:8'h02, last:1'b0});
    beats.push_back('{port:0, data:8'h03, last:1'b1});
    beats.push_back('{port:2, data:8'h21, last:1'b0});
    beats.push_back('{port:2, data:8'h22, last:1'b1});
    rdy_pat.push_back(1'b1);
    run_seq("b2b", 1'b1, 1'b1);

    // Output backpressure 1,0,0,1 repeating during a 4-beat frame.
    beats.push_back('{port:3, data:8'hB1, last:1'b0});
    beats.push_back('{port:3, data:8'hB2, last:1'b0});
    beats.push_back('{port:3, data:8'hB3, last:1'b0});
    beats.push_back('{port:3, data:8'hB4, last:1'b1});
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    run_seq("backpressure", 1'b0, 1'b0);

    // Grant invalid for two cycles mid-frame.
    beats.push_back('{port:2, data:8'hC1, last:1'b0});
    beats.push_back('{port:2, data:8'hC2, last:1'b0});
    beats.push_back('{port:2, data:8'hC3, last:1'b0});
    beats.push_back('{port:2, data:8'hC4, last:1'b1});
    rdy_pat.push_back(1'b1);
    gap_start = 2;
    gap_len   = 2;
    run_seq("glitch", 1'b1, 1'b0);

    // Async reset between edges while beat 2 is on the input.
    @(negedge clk);
    arb_grant_valid = 1'b1; arb_grant = 4'b1000; arb_grant_encoded = 2'd3;
    d[3] = 8'hD1; tvalid = 4'b1000; tlast = 4'b0000;
    @(negedge clk);
    check("pre-reset m_tvalid", 32'(m_axis_tvalid), 32'h1);
    check("pre-reset m_tdata", 32'(m_axis_tdata), 32'hD1);
    d[3] = 8'hD2;
    #2 rst_n = 1'b0;
    #1;
    check("async reset m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("async reset s_tready", 32'(s_axis_tready), 32'h0);
    check("async reset ack", 32'(arb_acknowledge), 32'h0);
    @(negedge clk);
    check("in reset m_tvalid", 32'(m_axis_tvalid), 32'h0);
    tvalid = '0;
    rst_n  = 1'b1;
    beats.push_back('{port:0, data:8'hE1, last:1'b0});
    beats.push_back('{port:0, data:8'hE2, last:1'b1});
    rdy_pat.push_back(1'b1);
    run_seq("post-reset", 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
